// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERROR    = 2'd2
  } state_e;

  localparam logic [1:0] FWD_RF      = 2'b00;
  localparam logic [1:0] FWD_EXE     = 2'b01;
  localparam logic [1:0] FWD_MEM_ALU = 2'b10;
  localparam logic [1:0] FWD_MEM_LD  = 2'b11;

  localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/fwd_sel.sv
// Operand forwarding select for one ID-stage source register.
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] src_i,
  input  logic       exe_wreg_i,
  input  logic       exe_m2reg_i,
  input  logic [4:0] exe_rn_i,
  input  logic       mem_wreg_i,
  input  logic       mem_m2reg_i,
  input  logic [4:0] mem_rn_i,
  output logic [1:0] sel_o
);

  // A load still in EXE has no data yet; it is covered by the load-use stall instead.
  always_comb begin
    sel_o = FWD_RF;
    if (src_i != REG_ZERO) begin
      if (exe_wreg_i && !exe_m2reg_i && (exe_rn_i == src_i)) begin
        sel_o = FWD_EXE;
      end else if (mem_wreg_i && (mem_rn_i == src_i)) begin
        sel_o = mem_m2reg_i ? FWD_MEM_LD : FWD_MEM_ALU;
      end
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage pipeline, including the
// data-memory wait sequencer with timeout and a saturating stall counter.
module pipe_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int WAIT_MAX = 16,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_branch_taken,
  input  logic [4:0]       exe_rn,
  input  logic [4:0]       mem_rn,
  input  logic             exe_wreg,
  input  logic             exe_m2reg,
  input  logic             mem_wreg,
  input  logic             mem_m2reg,
  input  logic             mem_wmem,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             if_id_en,
  output logic             id_exe_en,
  output logic             exe_mem_en,
  output logic             id_exe_bubble,
  output logic             mem_wb_bubble,
  output logic             if_id_flush,
  output logic             dmem_req,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int WCNT_W = $clog2(WAIT_MAX);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

  state_e             state_q, state_d;
  logic [WCNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic               mem_err_q, mem_err_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

  logic       mem_acc, freeze, load_use;
  logic [1:0] sel_a, sel_b;

  fwd_sel u_fwd_rs (
    .src_i       (id_rs),
    .exe_wreg_i  (exe_wreg),
    .exe_m2reg_i (exe_m2reg),
    .exe_rn_i    (exe_rn),
    .mem_wreg_i  (mem_wreg),
    .mem_m2reg_i (mem_m2reg),
    .mem_rn_i    (mem_rn),
    .sel_o       (sel_a)
  );

  fwd_sel u_fwd_rt (
    .src_i       (id_rt),
    .exe_wreg_i  (exe_wreg),
    .exe_m2reg_i (exe_m2reg),
    .exe_rn_i    (exe_rn),
    .mem_wreg_i  (mem_wreg),
    .mem_m2reg_i (mem_m2reg),
    .mem_rn_i    (mem_rn),
    .sel_o       (sel_b)
  );

  assign mem_acc  = mem_m2reg | mem_wmem;
  assign freeze   = (state_q == ERROR) | (mem_acc & ~dmem_ready);
  assign load_use = exe_wreg & exe_m2reg & (exe_rn != REG_ZERO) &
                    ((id_use_rs & (exe_rn == id_rs)) | (id_use_rt & (exe_rn == id_rt)));

  always_comb begin
    pc_en         = 1'b1;
    if_id_en      = 1'b1;
    id_exe_en     = 1'b1;
    exe_mem_en    = 1'b1;
    id_exe_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    if_id_flush   = 1'b0;
    dmem_req      = 1'b0;
    fwd_a         = FWD_RF;
    fwd_b         = FWD_RF;
    if (clr) begin
      pc_en         = 1'b0;
      if_id_en      = 1'b0;
      id_exe_en     = 1'b0;
      exe_mem_en    = 1'b0;
      id_exe_bubble = 1'b1;
      mem_wb_bubble = 1'b1;
    end else begin
      dmem_req = mem_acc & (state_q != ERROR);
      fwd_a    = sel_a;
      fwd_b    = sel_b;
      if (freeze) begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_exe_en     = 1'b0;
        exe_mem_en    = 1'b0;
        mem_wb_bubble = 1'b1;
      end else if (load_use) begin
        pc_en         = 1'b0;
        if_id_en      = 1'b0;
        id_exe_bubble = 1'b1;
      end else begin
        if_id_flush = id_branch_taken;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      RUN: begin
        if (mem_acc && !dmem_ready) begin
          state_d    = MEM_WAIT;
          wait_cnt_d = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          state_d = RUN;
        end else if (wait_cnt_q == WAIT_LAST) begin
          state_d = ERROR;
        end else begin
          wait_cnt_d = wait_cnt_q + WCNT_W'(1);
        end
      end
      default: state_d = ERROR;
    endcase
    mem_err_d   = mem_err_q | (state_d == ERROR);
    stall_cnt_d = stall_cnt_q;
    if (!pc_en && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q     <= RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush/forwarding controller for the 5-stage pipeline. It drives the enable and bubble inputs of the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers and selects the ID-stage operand forwarding sources. It also sequences multi-cycle data-memory accesses through a req/ready handshake with a timeout. It sits beside the pipeline registers and sees only register numbers and control bits, never data.

## Interface
Parameters:
- WAIT_MAX, 16: maximum data-memory wait cycles before an error is declared; legal range 2..65535.
- CNT_W, 16: width of the performance stall counter.

Ports:
- clk  in  1  pipeline clock.
- clr  in  1  reset; one clock, synchronous, active-high.
- id_rs, id_rt  in  5  source register numbers of the instruction in ID.
- id_use_rs, id_use_rt  in  1  the ID instruction reads rs / rt.
- id_branch_taken  in  1  branch/jump resolved taken in ID.
- exe_rn, mem_rn  in  5  destination register numbers in EXE and MEM.
- exe_wreg, exe_m2reg, mem_wreg, mem_m2reg, mem_wmem  in  1  stage control bits.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_exe_en, exe_mem_en  out  1  register load enables.
- id_exe_bubble, mem_wb_bubble  out  1  load a NOP (all write enables 0) instead of the upstream stage.
- if_id_flush  out  1  clear IF/ID to NOP.
- dmem_req  out  1  data-memory access request.
- fwd_a, fwd_b  out  2  operand select: 00 register file, 01 EXE ALU result, 10 MEM ALU result, 11 MEM load data.
- mem_err  out  1  sticky memory-timeout flag.
- stall_cnt  out  CNT_W  saturating count of cycles with pc_en=0.

## Operation
- Memory access: mem_acc = mem_m2reg | mem_wmem. dmem_req = mem_acc in RUN and MEM_WAIT states.
- Freeze: mem_acc & !dmem_ready, or state ERROR.
  - pc_en, if_id_en, id_exe_en and exe_mem_en are all 0.
  - mem_wb_bubble = 1.
  - if_id_flush and id_exe_bubble are 0.
- Load-use: exe_wreg & exe_m2reg & exe_rn≠0 & ((id_use_rs & exe_rn==id_rs) | (id_use_rt & exe_rn==id_rt)).
  - If not frozen: pc_en = if_id_en = 0, id_exe_bubble = 1, exe_mem_en = 1.
- Branch: if_id_flush = id_branch_taken & !freeze & !load-use. A branch stalled by load-use is re-evaluated the next cycle.
- Otherwise: all enables 1, both bubbles 0.
- Forwarding for fwd_a on id_rs; fwd_b is identical on id_rt. Register 0 never matches. EXE has priority over MEM.
  - exe_wreg & !exe_m2reg & exe_rn==id_rs → 01.
  - else mem_wreg & mem_rn==id_rs → 11 if mem_m2reg, else 10.
  - else 00.
- FSM states: RUN, MEM_WAIT, ERROR.
  - RUN → MEM_WAIT when mem_acc & !dmem_ready; wait_cnt is set to 1.
  - In MEM_WAIT, dmem_ready → RUN.
  - In MEM_WAIT, otherwise wait_cnt increments; if wait_cnt == WAIT_MAX-1 → ERROR.
  - ERROR: mem_err = 1, freeze held, dmem_req = 0. Leaves only on clr.
- stall_cnt: +1 each non-reset cycle with pc_en=0; saturates at all-ones.

## Timing
- Enables, bubbles, flush, dmem_req and fwd are combinational from same-cycle inputs and state; zero-cycle latency.
- State, wait_cnt, mem_err and stall_cnt update on the clk rising edge.
- Reset (clr=1, sampled at the edge): state RUN, wait_cnt 0, mem_err 0, stall_cnt 0.
- While clr=1, outputs are forced to:
  - all enables 0, both bubbles 1, if_id_flush 0;
  - dmem_req 0, fwd_a = fwd_b = 00.
- Reset asserted mid-wait drops dmem_req immediately; the memory must tolerate request withdrawal.
- Load-use stall lasts exactly 1 cycle: the bubble moves the load to MEM, where MEM forwarding (11) takes over.
- Simultaneous freeze + load-use + branch: freeze wins. Load-use and branch are re-evaluated after release, because the pipeline registers hold.
- dmem_ready in the same cycle as the request: no freeze, no state change.

## Structure
- Shared package pipe_pkg holds:
  - the state enum (RUN, MEM_WAIT, ERROR);
  - the fwd select constants (FWD_RF, FWD_EXE, FWD_MEM_ALU, FWD_MEM_LD);
  - REG_ZERO = 5'd0.
- One sub-module, fwd_sel: combinational per-operand forwarding select, instantiated twice (rs and rt).
- Hazard logic, FSM and counters live in pipe_hazard_ctrl.

## Test plan
- Load-use: exe_m2reg=1, exe_wreg=1, exe_rn=5, id_rs=5, id_use_rs=1 → one cycle of pc_en=0, if_id_en=0, id_exe_bubble=1. The next cycle has fwd_a=11 and stall_cnt=1.
- Forwarding priority: exe_rn=mem_rn=7 (ALU, both wreg), id_rt=7 → fwd_b=01. With exe_wreg=0 → fwd_b=10. With id_rt=0 and both rn=0 → fwd_b=00.
- Branch vs stall: id_branch_taken=1 together with a load-use hazard → if_id_flush=0. The next cycle, with the hazard cleared → if_id_flush=1.
- Memory wait: mem_m2reg=1, dmem_ready low for 3 cycles, high on the 4th → freeze for 3 cycles, then RUN; stall_cnt=3; mem_err=0.
- Timeout: WAIT_MAX=4, dmem_ready held 0 → ERROR after cycle 4 with mem_err=1 and dmem_req=0. A clr pulse returns to RUN with all counters 0.
